sw_sample_capture: RTL and testbench

- Input-side counterpart to the seven-segment output path: turns the 16 slide switches and one capture pushbutton into a clean, handshaked stream of signed samples for the TDNN core.
- Synchronises and debounces the switches and button. On each debounced button press, pushes the debounced switch word into a small first-word-fall-through (FWFT) FIFO.
- Presents the FIFO head to TDNN with a valid/ready handshake, replacing the direct sw-to-SIG_IN wiring at the top level.

---
 rtl/tdnn_pkg.sv | 18 +
 rtl/sample_fifo.sv | 71 +++++++
 rtl/sw_sample_capture.sv | 137 +++++++++++++
 tb/tb_sw_sample_capture.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tdnn_pkg.sv
// Shared types and constants for the TDNN sample path.
//   SIG_SIZE    : sample width, tied to the 16 board slide switches
//   btn_state_t : capture-button debounce states
//   sample_t    : signed sample word handed to the TDNN core
package tdnn_pkg;

    localparam int unsigned SIG_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    typedef logic signed [SIG_SIZE-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO with valid/ready read side.
//   clk, rst  : clock, synchronous active-high reset
//   push/data : write strobe and sample to store
//   ready     : consumer takes head this cycle (ignored while empty)
//   head      : oldest stored sample, meaningful while valid = 1
//   valid     : FIFO not empty
//   count     : number of entries held
//   overflow  : sticky, a push was dropped because the FIFO was full
module sample_fifo
    import tdnn_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  sample_t                 data,
    input  logic                    ready,
    output sample_t                 head,
    output logic                    valid,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    sample_t         mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            pop_c;
    logic            full_c;
    logic            push_ok_c;

    assign valid     = (count != '0);
    assign full_c    = (count == CW'(DEPTH));
    assign pop_c     = valid && ready;
    // A pop on the same edge frees the slot the write pointer is sitting on.
    assign push_ok_c = push && (!full_c || pop_c);
    assign head      = mem[rd_ptr];

    // Storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok_c) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && !push_ok_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_sample_capture.sv
// Switch/button sample capture front end for the TDNN core.
// Synchronises and debounces 16 slide switches and a capture button; each
// debounced press pushes the debounced switch word into a FWFT FIFO whose
// head is offered to the consumer with a valid/ready handshake.
//   topclk, rst : clock, synchronous active-high reset
//   sw, btn     : raw asynchronous switches and capture button
//   sig_out     : FIFO head sample, valid while sig_valid = 1
//   sig_valid   : FIFO not empty
//   sig_ready   : consumer accepts sig_out this cycle
//   fifo_count  : entries held
//   overflow    : sticky, a capture was dropped on a full FIFO
module sw_sample_capture
    import tdnn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                          topclk,
    input  logic                          rst,
    input  logic [SIG_SIZE-1:0]           sw,
    input  logic                          btn,
    output sample_t                       sig_out,
    output logic                          sig_valid,
    input  logic                          sig_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SIG_SIZE-1:0] sw_meta;
    logic [SIG_SIZE-1:0] sw_s;
    logic                btn_meta;
    logic                btn_s;
    logic [SIG_SIZE-1:0] sw_last;
    sample_t             sw_db;
    logic [CW-1:0]       sw_cnt;
    logic [CW-1:0]       b_cnt;
    btn_state_t          state;
    logic                push_c;

    // Two-flop synchronisers for switches and button.
    always_ff @(posedge topclk) begin
        if (rst) begin
            sw_meta  <= '0;
            sw_s     <= '0;
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            sw_meta  <= sw;
            sw_s     <= sw_meta;
            btn_meta <= btn;
            btn_s    <= btn_meta;
        end
    end

    // Switch word debounce: any bit change restarts the shared stability count.
    always_ff @(posedge topclk) begin
        if (rst) begin
            sw_last <= '0;
            sw_db   <= '0;
            sw_cnt  <= '0;
        end else if (sw_s != sw_last) begin
            sw_last <= sw_s;
            sw_cnt  <= '0;
        end else if (sw_cnt == CNT_LAST) begin
            sw_db <= sample_t'(sw_last);
        end else begin
            sw_cnt <= sw_cnt + CW'(1);
        end
    end

    // Button debounce FSM; one counter is reused for press and release.
    always_ff @(posedge topclk) begin
        if (rst) begin
            state <= IDLE;
            b_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_WAIT;
                        b_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (b_cnt == CNT_LAST) begin
                        state <= HELD;
                    end else begin
                        b_cnt <= b_cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        b_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state <= HELD;
                    end else if (b_cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        b_cnt <= b_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    b_cnt <= '0;
                end
            endcase
        end
    end

    // Push strobe coincides with the PRESS_WAIT -> HELD edge so the FIFO
    // write lands on that same edge.
    assign push_c = (state == PRESS_WAIT) && btn_s && (b_cnt == CNT_LAST);

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (topclk),
        .rst      (rst),
        .push     (push_c),
        .data     (sw_db),
        .ready    (sig_ready),
        .head     (sig_out),
        .valid    (sig_valid),
        .count    (fifo_count),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_sw_sample_capture.sv
// Directed bench for sw_sample_capture with DEBOUNCE_CYCLES = 4, FIFO_DEPTH = 4.
module tb_sw_sample_capture;

    logic        topclk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic        btn;
    logic [15:0] sig_out;
    logic        sig_valid;
    logic        sig_ready;
    logic [2:0]  fifo_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    sw_sample_capture #(
        .DEBOUNCE_CYCLES (4),
        .FIFO_DEPTH      (4)
    ) dut (
        .topclk     (topclk),
        .rst        (rst),
        .sw         (sw),
        .btn        (btn),
        .sig_out    (sig_out),
        .sig_valid  (sig_valid),
        .sig_ready  (sig_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 topclk = ~topclk;

    typedef struct {
        logic        rst;
        logic [15:0] sw;
        logic        btn;
        logic        ready;
        int          ncyc;
        logic        valid;
        logic [15:0] out;
        logic [2:0]  cnt;
        logic        ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge topclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic v, input logic [15:0] o,
                           input logic [2:0] c, input logic f);
        chk({name, ".valid"}, 32'(sig_valid), 32'(v));
        chk({name, ".out"}, 32'(sig_out), 32'(o));
        chk({name, ".count"}, 32'(fifo_count), 32'(c));
        chk({name, ".ovf"}, 32'(overflow), 32'(f));
    endtask

    // Settle the switch word, then one clean press and release.
    task automatic press(input logic [15:0] v);
        sw = v;
        repeat (8) tick();
        btn = 1'b1;
        repeat (8) tick();
        btn = 1'b0;
        repeat (8) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Check head against expected value, then pop it with a one-cycle ready.
    task automatic pop_expect(input string name, input logic [15:0] v);
        chk({name, ".valid"}, 32'(sig_valid), 32'd1);
        chk({name, ".out"}, 32'(sig_out), 32'(v));
        sig_ready = 1'b1;
        tick();
        sig_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sw = '0; btn = 1'b0; sig_ready = 1'b0;

        // Reset, switch settle, basic capture latency (push on 7th high edge) and pop.
        vecs[0] = '{1'b1, 16'h0000, 1'b0, 1'b0, 3, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[1] = '{1'b0, 16'hA5C3, 1'b0, 1'b0, 8, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[2] = '{1'b0, 16'hA5C3, 1'b1, 1'b0, 6, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[3] = '{1'b0, 16'hA5C3, 1'b1, 1'b0, 1, 1'b1, 16'hA5C3, 3'd1, 1'b0};
        vecs[4] = '{1'b0, 16'hA5C3, 1'b1, 1'b0, 3, 1'b1, 16'hA5C3, 3'd1, 1'b0};
        vecs[5] = '{1'b0, 16'hA5C3, 1'b0, 1'b0, 6, 1'b1, 16'hA5C3, 3'd1, 1'b0};
        vecs[6] = '{1'b0, 16'hA5C3, 1'b0, 1'b1, 1, 1'b0, 16'h0000, 3'd0, 1'b0};
        vecs[7] = '{1'b0, 16'hA5C3, 1'b0, 1'b0, 4, 1'b0, 16'h0000, 3'd0, 1'b0};

        for (int i = 0; i < 8; i++) begin
            rst       = vecs[i].rst;
            sw        = vecs[i].sw;
            btn       = vecs[i].btn;
            sig_ready = vecs[i].ready;
            repeat (vecs[i].ncyc) tick();
            chk_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].out,
                    vecs[i].cnt, vecs[i].ovf);
        end
        sig_ready = 1'b0;

        // Bounce: 1,0,1,0 then held high -> exactly one push.
        btn = 1'b1; tick();
        btn = 1'b0; tick();
        btn = 1'b1; tick();
        btn = 1'b0; tick();
        btn = 1'b1;
        repeat (6) tick();
        chk("bounce_early.count", 32'(fifo_count), 32'd0);
        repeat (2) tick();
        chk("bounce_push.count", 32'(fifo_count), 32'd1);
        chk("bounce_push.out", 32'(sig_out), 32'hA5C3);
        // 3-cycle glitch low while HELD must not retrigger.
        btn = 1'b0;
        repeat (3) tick();
        btn = 1'b1;
        repeat (8) tick();
        btn = 1'b0;
        repeat (8) tick();
        chk("glitch.count", 32'(fifo_count), 32'd1);
        pop_expect("bounce_pop", 16'hA5C3);
        chk("bounce_pop.count", 32'(fifo_count), 32'd0);

        // Overflow: five presses into a depth-4 FIFO with no consumer.
        for (int i = 1; i <= 5; i++) press(16'(i));
        chk("ovf.count", 32'(fifo_count), 32'd4);
        chk("ovf.flag", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) pop_expect($sformatf("ovf_drain%0d", i), 16'(i));
        chk("ovf_drained.valid", 32'(sig_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Simultaneous push and pop while full.
        do_reset();
        chk("rst2.ovf", 32'(overflow), 32'd0);
        for (int i = 1; i <= 4; i++) press(16'(i));
        chk("full.count", 32'(fifo_count), 32'd4);
        sw = 16'h8000;
        repeat (8) tick();
        btn = 1'b1;
        repeat (6) tick();
        chk("hold_head.out", 32'(sig_out), 32'h0001);
        sig_ready = 1'b1;
        tick();
        sig_ready = 1'b0;
        chk("pushpop.count", 32'(fifo_count), 32'd4);
        chk("pushpop.ovf", 32'(overflow), 32'd0);
        tick();
        btn = 1'b0;
        repeat (8) tick();
        pop_expect("pp_drain0", 16'h0002);
        pop_expect("pp_drain1", 16'h0003);
        pop_expect("pp_drain2", 16'h0004);
        pop_expect("pp_drain3", 16'h8000);
        chk("pp_drained.count", 32'(fifo_count), 32'd0);

        // Reset mid-operation with two samples buffered and FSM in PRESS_WAIT.
        press(16'h0011);
        press(16'h0022);
        chk("pre_rst.count", 32'(fifo_count), 32'd2);
        sw = 16'h0000;
        repeat (8) tick();
        btn = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk_all("mid_rst", 1'b0, 16'h0000, 3'd0, 1'b0);
        rst = 1'b0;
        repeat (6) tick();
        chk("post_rst_early.valid", 32'(sig_valid), 32'd0);
        tick();
        chk_all("post_rst_push", 1'b1, 16'h0000, 3'd1, 1'b0);
        repeat (8) tick();
        chk("post_rst_single.count", 32'(fifo_count), 32'd1);
        btn = 1'b0;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
